// File: rtl/uart_tx_cfg_if.sv
// Client-side handshake and serial-line bundle for uart_tx_cfg.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 start;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic                 tx;

  modport master (output data, output start, input ready, input busy, input done, input tx);
  modport slave  (input data, input start, output ready, output busy, output done, output tx);
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable bit period, width, parity and stop bits.
// A one-word holding register lets the next frame start with no idle gap.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (line low)
// DATA   | payload bits, LSB first
// PAR    | parity bit (never entered when PARITY = 0)
// STOP   | STOP_BITS stop periods (line high)
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave bus
);
  localparam int            TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TC        = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               r_state;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ready;

  logic w_accept;
  logic w_bit_end;
  logic w_frame_end;

  assign w_accept    = bus.start && r_ready;
  assign w_bit_end   = (r_timer == TC);
  assign w_frame_end = (r_state == STOP) && w_bit_end && (r_idx == LAST_STOP);

  assign bus.tx    = r_tx;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.ready = r_ready;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_par       <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE) r_timer <= w_bit_end ? '0 : r_timer + 1'b1;

      // An accept on the final stop edge goes straight to the shifter below.
      if (w_accept && (r_state != IDLE) && !w_frame_end) begin
        r_hold      <= bus.data;
        r_hold_full <= 1'b1;
        r_ready     <= 1'b0;
      end

      case (r_state)
        IDLE: if (w_accept) begin
          r_shift <= bus.data;
          r_par   <= par_of(bus.data);
          r_state <= START;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
          r_timer <= '0;
        end
        START: if (w_bit_end) begin
          r_state <= DATA;
          r_idx   <= '0;
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
        end
        DATA: if (w_bit_end) begin
          if (r_idx == LAST_DATA) begin
            r_idx <= '0;
            if (PARITY != 0) begin
              r_state <= PAR;
              r_tx    <= r_par;
            end else begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        PAR: if (w_bit_end) begin
          r_state <= STOP;
          r_tx    <= 1'b1;
          r_idx   <= '0;
        end
        STOP: if (w_bit_end) begin
          if (r_idx != LAST_STOP) begin
            r_idx <= r_idx + 4'd1;
          end else begin
            r_done <= 1'b1;
            r_idx  <= '0;
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_par       <= par_of(r_hold);
              r_state     <= START;
              r_tx        <= 1'b0;
              r_hold_full <= 1'b0;
              r_ready     <= 1'b1;
            end else if (w_accept) begin
              r_shift <= bus.data;
              r_par   <= par_of(bus.data);
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with configurable bit period, data width, parity and stop-bit count, plus a one-word holding register so consecutive frames go out back-to-back with no idle gap. It sits between a byte-producing client (valid/ready handshake) and the serial `tx` pin. It replaces the fixed 8N1 transmitter in new designs.

## Interface
- `CLKS_PER_BIT`, 104: clock cycles per serial bit; legal range 2..65535.
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  DATA_BITS  payload; sampled only on an accepting edge.
- `start`  in  1  request to send `data` (valid).
- `ready`  out  1  transmitter can accept a word this cycle.
- `busy`  out  1  a frame is on the line.
- `done`  out  1  one-cycle pulse at the end of each frame's last stop bit.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- Reset (async, while `rst_n`=0): `tx`=1, `ready`=1, `busy`=0, `done`=0, state IDLE, holding register empty, bit timer and bit index 0. Reset mid-frame aborts the frame and drops any held word; `tx` goes high immediately.
- Accept: `start && ready` at a rising edge. `start` while `ready`=0 is ignored and has no effect.
- `ready` = holding register empty.
- Accept while IDLE: the word loads directly into the shifter, state goes to START, and `tx` goes to 0 at that same edge. The holding register stays empty, so `ready` stays 1.
- Accept while a frame is in progress: the word loads into the holding register, and `ready` goes to 0 from the next cycle.
- States:
  - IDLE: `tx`=1, `busy`=0.
  - START: `tx`=0.
  - DATA: `tx`=shift[idx], LSB first, idx 0..DATA_BITS-1.
  - PARITY: skipped when PARITY=0.
  - STOP: `tx`=1, STOP_BITS bit periods.
- Each bit lasts exactly CLKS_PER_BIT cycles. The timer counts 0..CLKS_PER_BIT-1, and the state/bit advances when the timer is CLKS_PER_BIT-1; the timer then wraps to 0.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: inverse of that XOR.
  - The parity bit is computed from the word latched into the shifter, not from the live `data` input.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- End of the last stop bit (timer = CLKS_PER_BIT-1 in the final STOP period):
  - `done` is 1 for the following cycle.
  - Holding register full: the shifter loads the held word, state goes to START, `tx` goes to 0 at that edge (no idle gap), the holding register clears, and `ready` is 1 from the next cycle.
  - Holding register empty: state goes to IDLE and `busy` goes to 0.
- An accept on the same edge that the holding register drains cannot occur, because `ready` was 0 in that cycle.

## Timing
- Latency for an accept at edge N while IDLE: `tx` falls after edge N, and `busy`=1 from edge N.
- `busy` falls at the edge where IDLE is entered, coincident with `done` rising.
- `ready` is a registered output with no combinational path from `start`.
- Timer width: ceil(log2(CLKS_PER_BIT)) bits.
- Bit index width: 4 bits.

## Test plan
- **Basic 8N1 frame.** CLKS_PER_BIT=4, 8N1, idle, `start` with `data`=0xA5 for one cycle.
  - Required `tx`, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for 40 cycles; `done` pulses on cycle 40.
- **Back-to-back frames.** 0x55 accepted while IDLE, then 0x0F accepted 5 cycles later.
  - `ready` is 0 from cycle 6 until the first frame ends.
  - The second start bit begins on the cycle immediately after the first frame's stop bit: no high gap beyond one stop bit, `busy` never drops, `done` pulses twice.
- **Parity and stop bits.** DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, `data`=0x03.
  - Parity bit 0; frame length 11 bits = 44 cycles.
  - With PARITY=1 (odd), the same data gives parity bit 1.
- **Ignored start.** Hold `start`=1 continuously with the holding register full.
  - No extra words are accepted while `ready`=0.
  - Exactly one new accept occurs on the cycle `ready` returns to 1.
- **Reset mid-frame.** Assert `rst_n`=0 during DATA bit 3 with a word held.
  - `tx`=1 immediately (asynchronously), `busy`=0, `ready`=1.
  - After release, the line stays idle, and a new 0x81 frame transmits correctly.
- **9-bit data, minimum period.** DATA_BITS=9, CLKS_PER_BIT=2, `data`=0x1FF.
  - Nine 1-bits of 2 cycles each; `tx` low only during the start bit.
